// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg : shared types and limits for the bit-serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_MIN = 2;
    localparam int SA_WIDTH_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : full adder built from two half adders and an OR
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (w_s0),
        .c (w_c0)
    );

    half_adder u_ha1 (
        .a (w_s0),
        .b (cin),
        .s (s),
        .c (w_c1)
    );

    assign cout = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// half_adder : one-bit half adder (sum = a ^ b, carry = a & b)
// Rev 1.0
// ============================================================================
`default_nettype none

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial adder, one full-adder cell over WIDTH cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    sa_state_t        r_state;
    sa_state_t        w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_unused_lsb;

    full_adder_cell u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_last       = (r_bit_cnt == C_LAST);
    assign w_sum_next   = {w_s, r_sum_sh[WIDTH-1:1]};
    // The LSB of the shift register is always shifted out before the result is taken.
    assign w_unused_lsb = r_sum_sh[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_carry   <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_sum_sh  <= w_sum_next;
                    r_carry   <= w_c;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_last) begin
                        sum  <= w_sum_next;
                        cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl : scoreboard bench for serial_add_ctrl (WIDTH=8 and 2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cout, busy;
    logic [7:0] a, b, sum;
    logic       in_valid_2, in_ready_2, out_valid_2, out_ready_2, cout_2, busy_2;
    logic [1:0] a_2, b_2, sum_2;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_2),
        .in_ready  (in_ready_2),
        .a         (a_2),
        .b         (b_2),
        .out_valid (out_valid_2),
        .out_ready (out_ready_2),
        .sum       (sum_2),
        .cout      (cout_2),
        .busy      (busy_2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept8(input logic [7:0] ta, input logic [7:0] tb_);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_ready: got in_ready=%b want 1", in_ready);
            bad++;
        end
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        q8.push_back({1'b0, ta} + {1'b0, tb_});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result8(input string tag, input int exp_lat, output logic [8:0] exp);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin
            $display("FAIL %s_latency: got %0d cycles want %0d", tag, lat, exp_lat);
            bad++;
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        total++;
        if ({cout, sum} !== exp) begin
            $display("FAIL %s_result: got {cout,sum}=%h want %h", tag, {cout, sum}, exp);
            bad++;
        end
    endtask

    task automatic release8(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s_release: got ov=%b ir=%b busy=%b want 0 1 0",
                     tag, out_valid, in_ready, busy);
            bad++;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        in_valid_2  = 1'b0;
        out_ready_2 = 1'b0;
        a_2         = '0;
        b_2         = '0;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
            bad++;
        end
        total++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            $display("FAIL reset_result: got sum=%h cout=%b want 00 0", sum, cout);
            bad++;
        end
        total++;
        if (in_ready_2 !== 1'b1 || out_valid_2 !== 1'b0 || busy_2 !== 1'b0 || {cout_2, sum_2} !== 3'b000) begin
            $display("FAIL reset_w2: got ir=%b ov=%b busy=%b res=%b want 1 0 0 000",
                     in_ready_2, out_valid_2, busy_2, {cout_2, sum_2});
            bad++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carry_ripple;
        logic [8:0] exp;
        out_ready = 1'b1;
        accept8(8'hFF, 8'h01);
        wait_result8("ripple_ff01", 8, exp);
        release8("ripple_ff01");
        out_ready = 1'b1;
        accept8(8'hA5, 8'h5A);
        wait_result8("ripple_a55a", 8, exp);
        release8("ripple_a55a");
    endtask

    task automatic test_backpressure;
        logic [8:0] exp;
        out_ready = 1'b0;
        accept8(8'h80, 8'h80);
        wait_result8("bp", 8, exp);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || {cout, sum} !== 9'h100) begin
                $display("FAIL bp_hold%0d: got ov=%b res=%h want 1 100", i, out_valid, {cout, sum});
                bad++;
            end
        end
        release8("bp");
    endtask

    task automatic test_busy_reject;
        logic [8:0] exp;
        accept8(8'h34, 8'h21);
        repeat (3) tick();
        a        = 8'h12;
        b        = 8'h12;
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL reject_run: got ir=%b busy=%b want 0 1", in_ready, busy);
            bad++;
        end
        tick();
        in_valid = 1'b0;
        wait_result8("reject", 4, exp);
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reject_done_ready: got %b want 0", in_ready);
            bad++;
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 9'h055) begin
            $display("FAIL reject_done_hold: got ov=%b ir=%b res=%h want 1 0 055",
                     out_valid, in_ready, {cout, sum});
            bad++;
        end
        release8("reject");
    endtask

    task automatic test_reset_mid;
        logic [8:0] exp;
        accept8(8'h55, 8'h33);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        q8.delete();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {cout, sum} !== 9'h000) begin
            $display("FAIL rstmid_idle: got ov=%b ir=%b busy=%b res=%h want 0 1 0 000",
                     out_valid, in_ready, busy, {cout, sum});
            bad++;
        end
        rst_n = 1'b1;
        tick();
        accept8(8'h0F, 8'h01);
        wait_result8("rstmid_0f01", 8, exp);
        total++;
        if ({cout, sum} !== 9'h010) begin
            $display("FAIL rstmid_const: got %h want 010", {cout, sum});
            bad++;
        end
        release8("rstmid");
    endtask

    task automatic test_exhaustive_w2;
        logic [2:0] exp;
        int         lat;
        out_ready_2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a_2        = 2'(i);
                b_2        = 2'(j);
                in_valid_2 = 1'b1;
                q2.push_back(3'(i + j));
                tick();
                in_valid_2 = 1'b0;
                lat = 0;
                while (!out_valid_2 && lat < 20) begin
                    tick();
                    lat++;
                end
                exp = q2.pop_front();
                total++;
                if (lat !== 2 || {cout_2, sum_2} !== exp) begin
                    $display("FAIL w2_%0d_%0d: got lat=%0d res=%b want lat=2 res=%b",
                             i, j, lat, {cout_2, sum_2}, exp);
                    bad++;
                end
                tick();
                total++;
                if (out_valid_2 !== 1'b0 || in_ready_2 !== 1'b1) begin
                    $display("FAIL w2_release_%0d_%0d: got ov=%b ir=%b want 0 1",
                             i, j, out_valid_2, in_ready_2);
                    bad++;
                end
            end
        end
        out_ready_2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_exhaustive_w2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single full-adder cell, built from two `half_adder` instances plus an OR, across WIDTH clock cycles to add two WIDTH-bit operands. It sits between an upstream operand source and a downstream result sink, each with a valid/ready handshake. It serves as the first sequential consumer of the combinational adder cells, trading area for latency.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  operands on `a`/`b` are valid.
- `in_ready`  out  1  controller can accept operands; high only in IDLE.
- `a`  in  WIDTH  operand A, unsigned.
- `b`  in  WIDTH  operand B, unsigned.
- `out_valid`  out  1  `sum`/`cout` are valid; high only in DONE.
- `out_ready`  in  1  sink accepts the result.
- `sum`  out  WIDTH  (a + b) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`: load `a`→a_sh and `b`→b_sh, clear the carry flop, set bit_cnt=0, go to RUN.
- **RUN:** each cycle, the full-adder cell computes s and c from (a_sh[0], b_sh[0], carry).
  - s shifts into the MSB of sum_sh; sum_sh shifts right.
  - a_sh and b_sh shift right; carry←c; bit_cnt increments.
  - When bit_cnt==WIDTH-1 (last bit):
    - load the result registers: `sum`←final sum_sh, `cout`←c;
    - go to DONE.
- **DONE:**
  - `out_valid`=1; `sum`/`cout` held stable.
  - On `out_ready` go to IDLE.
- Arithmetic is unsigned; no overflow flag beyond `cout`.
- bit_cnt width is $clog2(WIDTH); it never wraps mid-operation because the exit compare is at WIDTH-1.
- Boundary conditions:
  - `in_valid` is ignored in RUN and DONE; `in_ready`=0 there, and operands are not re-sampled.
  - Backpressure: `out_valid`, `sum` and `cout` stay constant for as long as `out_ready`=0, with no timeout.
  - `out_ready` high in IDLE/RUN has no effect.
  - `sum`/`cout` keep the last result after leaving DONE. They are only meaningful while `out_valid`=1.
  - Reset mid-operation (RUN or DONE): the operation is discarded, no result is produced, and the FSM returns to IDLE.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0;
  - `sum`=0, `cout`=0;
  - a_sh, b_sh, sum_sh, carry and bit_cnt all 0.
- All outputs are registered or decoded directly from the state register; there is no combinational path from any input to any output.
- Latency: operands accepted at edge E0 give `out_valid`=1 after edge E_WIDTH, i.e. WIDTH cycles.
- Result handshake at edge E_{W+1} (with `out_ready`=1) returns to IDLE. The earliest next acceptance is E_{W+2}.
- Sustained throughput is one addition per WIDTH+2 cycles.

## Structure
- Shared package `serial_add_pkg`:
  - typedef enum logic [1:0] `sa_state_t` {IDLE, RUN, DONE};
  - constants `SA_WIDTH_MIN`=2 and `SA_WIDTH_MAX`=32.
- Sub-modules:
  - one sub-module `full_adder_cell` (A, B, Cin → S, Cout), built from two existing `half_adder` instances and an OR;
  - the controller instantiates exactly one cell.
- Elaboration-time assertion that WIDTH is within [SA_WIDTH_MIN, SA_WIDTH_MAX].

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0.
- **Carry ripple, WIDTH=8:**
  - stimulus: a=8'hFF, b=8'h01, `out_ready`=1;
  - required: `out_valid` rises exactly 8 cycles after acceptance with `sum`=8'h00 and `cout`=1;
  - required: then a=8'hA5, b=8'h5A → `sum`=8'hFF, `cout`=0.
- **Backpressure:** a=8'h80, b=8'h80 with `out_ready`=0 for 5 cycles after `out_valid` → `sum`=8'h00 and `cout`=1 held stable all 5 cycles; a single handshake follows, then IDLE.
- **Busy rejection:** pulse `in_valid` with a=8'h12 during RUN and again during DONE → ignored, the result matches the original operands, and `in_ready`=0 throughout.
- **Reset mid-operation:** assert `rst_n`=0 at bit_cnt=3 → next cycle IDLE with `out_valid`=0. A subsequent a=8'h0F, b=8'h01 gives `sum`=8'h10, `cout`=0.
- **Exhaustive, WIDTH=2:** all 16 (a, b) pairs → {`cout`,`sum`} == a+b, with each result appearing 2 cycles after acceptance.
